alu_arbiter: RTL and testbench
==============================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, giving the operand width in bits.
REQ-002 The block SHALL have parameter RES_W, default 8, giving the result width in bits, with RES_W >= WIDTH+1.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 req0_valid  input  1  requester 0 has an operation pending.
REQ-006 req0_ready  output  1  requester 0 operation accepted this cycle.
REQ-007 req0_a, req0_b  input  WIDTH each  requester 0 operands.
REQ-008 req0_sel  input  2  requester 0 op: 2'b00 add, any other value subtract.
REQ-009 req1_valid, req1_ready, req1_a, req1_b, req1_sel SHALL mirror REQ-005..REQ-008 for requester 1.
REQ-010 rsp_valid  output  1  result held on rsp_* is valid.
REQ-011 rsp_ready  input  1  consumer accepts the result.
REQ-012 rsp_id  output  1  requester index that owns the result.
REQ-013 rsp_result  output  RES_W  zero-extended WIDTH-bit sum or difference.
REQ-014 rsp_cout  output  1  carry-out for add, borrow-out for subtract.
REQ-015 busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-016 The FSM SHALL have three states: IDLE, EXEC, RESP.
REQ-017 In IDLE with at least one reqN_valid high, the block SHALL grant exactly one requester, assert that reqN_ready combinationally for that cycle, capture its operands, sel and index, and move to EXEC.
REQ-018 reqN_ready SHALL be low in EXEC and RESP, and low for any requester not granted.
REQ-019 Arbitration SHALL be round-robin: with one requester valid, grant it; with both valid, grant the one not granted last.
REQ-020 The last-granted pointer SHALL update only on a grant.
REQ-021 In EXEC the block SHALL compute the sum for sel=00 and the difference otherwise on the captured operands, register the result, and move to RESP.
REQ-022 Add: {rsp_cout, rsp_result[WIDTH-1:0]} = a + b.
REQ-023 Subtract: rsp_result[WIDTH-1:0] = (a - b) mod 2^WIDTH; rsp_cout = 1 if a < b (unsigned), else 0.
REQ-024 rsp_result[RES_W-1:WIDTH] SHALL be zero.
REQ-025 In RESP, rsp_valid SHALL be high and rsp_id, rsp_result and rsp_cout SHALL stay stable until rsp_ready is sampled high.
REQ-026 When rsp_ready is sampled high in RESP, the FSM SHALL return to IDLE.
REQ-027 A new grant SHALL NOT occur in the same cycle as the RESP-to-IDLE transition.
REQ-028 Latency from the grant edge to rsp_valid high SHALL be 2 cycles; minimum throughput is one operation per 3 cycles.
REQ-029 rsp_ready high outside RESP SHALL have no effect.
REQ-030 reqN_valid dropping before it is granted SHALL cancel that request with no side effect.
REQ-031 Operand or sel changes after capture SHALL NOT alter the in-flight result.
REQ-032 WIDTH-bit arithmetic SHALL wrap modulo 2^WIDTH, with the overflow reported only through rsp_cout.

Reset
REQ-033 When rst_n is low, the block SHALL immediately force: state IDLE, rsp_valid 0, rsp_id 0, rsp_result 0, rsp_cout 0, busy 0, and the last-granted pointer to 1 so requester 0 wins the first contention.
REQ-034 Reset asserted in EXEC or RESP SHALL discard the in-flight operation with no response issued.
REQ-035 reqN_ready SHALL be 0 while rst_n is low.
REQ-036 After rst_n deasserts, the first grant SHALL be possible on the first rising clk edge.

Verification
REQ-037 Single add: req0 a=4'h9, b=4'h8, sel=00, rsp_ready=1 -> rsp_valid 2 cycles after grant, rsp_id=0, rsp_result=8'h01, rsp_cout=1.
REQ-038 Single subtract with borrow: req1 a=3, b=5, sel=01 -> rsp_id=1, rsp_result=8'h0E, rsp_cout=1; a=5, b=3, sel=11 -> rsp_result=8'h02, rsp_cout=0.
REQ-039 Contention: both valid continuously after reset, rsp_ready=1 -> grant order 0,1,0,1, with rsp_id following that order and one response every 3 cycles.
REQ-040 Back-pressure: rsp_ready=0 for 5 cycles in RESP -> rsp_* held stable, both reqN_ready stay 0, busy=1; rsp_ready=1 -> IDLE next cycle.
REQ-041 Reset mid-operation: rst_n low during EXEC -> rsp_valid never asserts for that request, all outputs 0 immediately, and after release the next contention grants req0.
REQ-042 Operand change after grant: req0_a altered in the cycle after grant -> response reflects the captured operands only.

Source files
------------

// File: rtl/alu_arbiter_if.sv
// rtl/alu_arbiter_if.sv - request/response bundle between two requesters, the arbiter and the result consumer
//
// Purpose: groups the two requester channels and the response channel of
// alu_arbiter into one bundle.
// Ports (signals):
//   req0_valid/req0_ready/req0_a/req0_b/req0_sel  requester 0 channel
//   req1_valid/req1_ready/req1_a/req1_b/req1_sel  requester 1 channel
//   rsp_valid/rsp_ready/rsp_id/rsp_result/rsp_cout response channel
// Modports:
//   master  requester/consumer side (drives requests, accepts responses)
//   slave   arbiter side
interface alu_arbiter_if #(
  parameter int WIDTH = 4,
  parameter int RES_W = 8
);
  logic             req0_valid;
  logic             req0_ready;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;
  logic [1:0]       req0_sel;

  logic             req1_valid;
  logic             req1_ready;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;
  logic [1:0]       req1_sel;

  logic             rsp_valid;
  logic             rsp_ready;
  logic             rsp_id;
  logic [RES_W-1:0] rsp_result;
  logic             rsp_cout;

  modport master (
    output req0_valid, req0_a, req0_b, req0_sel,
    output req1_valid, req1_a, req1_b, req1_sel,
    output rsp_ready,
    input  req0_ready, req1_ready,
    input  rsp_valid, rsp_id, rsp_result, rsp_cout
  );

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_sel,
    input  req1_valid, req1_a, req1_b, req1_sel,
    input  rsp_ready,
    output req0_ready, req1_ready,
    output rsp_valid, rsp_id, rsp_result, rsp_cout
  );
endinterface

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - two-requester round-robin arbiter in front of a shared add/subtract unit
//
// Purpose: grants one of two requesters, captures its operation, computes
// a WIDTH-bit sum or difference and holds the result until the consumer
// accepts it. One operation in flight at a time (IDLE -> EXEC -> RESP).
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    alu_arbiter_if.slave: request channels 0/1 and response channel
//   busy   high whenever the FSM is not in IDLE
module alu_arbiter #(
  parameter int WIDTH = 4,
  parameter int RES_W = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  alu_arbiter_if.slave bus,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  // last-granted requester; resets to 1 so requester 0 wins first contention
  logic             last_gnt;

  logic             gnt0;
  logic             gnt1;
  logic             grant;

  logic [WIDTH-1:0] cap_a;
  logic [WIDTH-1:0] cap_b;
  logic             cap_sub;
  logic             cap_id;

  logic [WIDTH:0]   alu_out;

  logic             rsp_id_q;
  logic [RES_W-1:0] rsp_result_q;
  logic             rsp_cout_q;

  // Round-robin choice; only meaningful while in IDLE.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (state == IDLE) begin
      gnt0 = bus.req0_valid && (!bus.req1_valid || last_gnt);
      gnt1 = bus.req1_valid && (!bus.req0_valid || !last_gnt);
    end
  end

  assign grant = gnt0 || gnt1;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic. RESP always returns to IDLE, never straight to a new
  // grant, which fixes the three-cycle operation period.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant) state_nxt = EXEC;
      EXEC:    state_nxt = RESP;
      RESP:    if (bus.rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic. Ready is gated by rst_n because the state register is
  // already IDLE during reset and a valid request would otherwise see ready.
  always_comb begin
    bus.req0_ready = rst_n && gnt0;
    bus.req1_ready = rst_n && gnt1;
    bus.rsp_valid  = (state == RESP);
    busy           = (state != IDLE);
  end

  // Extra top bit carries the add carry-out, or the borrow for subtract
  // (zero-extended a minus zero-extended b goes negative exactly when a < b).
  always_comb begin
    alu_out = '0;
    if (cap_sub) begin
      alu_out = {1'b0, cap_a} - {1'b0, cap_b};
    end else begin
      alu_out = {1'b0, cap_a} + {1'b0, cap_b};
    end
  end

  // Capture on grant so later operand changes cannot reach the result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_gnt <= 1'b1;
      cap_a    <= '0;
      cap_b    <= '0;
      cap_sub  <= 1'b0;
      cap_id   <= 1'b0;
    end else if (grant) begin
      last_gnt <= gnt1;
      cap_id   <= gnt1;
      cap_a    <= gnt1 ? bus.req1_a : bus.req0_a;
      cap_b    <= gnt1 ? bus.req1_b : bus.req0_b;
      cap_sub  <= gnt1 ? (|bus.req1_sel) : (|bus.req0_sel);
    end
  end

  // Result registers load only in EXEC and therefore stay stable in RESP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_id_q     <= 1'b0;
      rsp_result_q <= '0;
      rsp_cout_q   <= 1'b0;
    end else if (state == EXEC) begin
      rsp_id_q     <= cap_id;
      rsp_result_q <= {{(RES_W-WIDTH){1'b0}}, alu_out[WIDTH-1:0]};
      rsp_cout_q   <= alu_out[WIDTH];
    end
  end

  assign bus.rsp_id     = rsp_id_q;
  assign bus.rsp_result = rsp_result_q;
  assign bus.rsp_cout   = rsp_cout_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - directed self-checking bench for alu_arbiter
module tb_alu_arbiter;

  logic clk;
  logic rst_n;
  logic busy;
  int   n_cmp;
  int   n_err;

  alu_arbiter_if #(.WIDTH(4), .RES_W(8)) bus ();

  alu_arbiter #(.WIDTH(4), .RES_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .busy  (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    bus.req0_valid = 1'b1;
    bus.req0_a = 4'h0; bus.req0_b = 4'h0; bus.req0_sel = 2'b00;
    bus.req1_valid = 1'b0;
    bus.req1_a = 4'h0; bus.req1_b = 4'h0; bus.req1_sel = 2'b00;
    bus.rsp_ready = 1'b1;

    // reset state, with a pending request that must not see ready
    #2;
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_result", bus.rsp_result, 0);
    chk("rst_cout", bus.rsp_cout, 0);
    chk("rst_id", bus.rsp_id, 0);
    chk("rst_rdy0", bus.req0_ready, 0);
    tick();
    chk("rst_edge_rdy0", bus.req0_ready, 0);
    chk("rst_edge_busy", busy, 0);

    // single add 9+8 -> 01 carry 1
    rst_n = 1'b1;
    bus.req0_a = 4'h9; bus.req0_b = 4'h8; bus.req0_sel = 2'b00;
    #1;
    chk("add_rdy0", bus.req0_ready, 1);
    chk("add_rdy1", bus.req1_ready, 0);
    tick();
    chk("add_exec_busy", busy, 1);
    chk("add_exec_valid", bus.rsp_valid, 0);
    chk("add_exec_rdy0", bus.req0_ready, 0);
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b1;
    bus.req1_a = 4'hA; bus.req1_b = 4'h1;
    tick();
    chk("add_resp_valid", bus.rsp_valid, 1);
    chk("add_resp_id", bus.rsp_id, 0);
    chk("add_resp_result", bus.rsp_result, 8'h01);
    chk("add_resp_cout", bus.rsp_cout, 1);
    chk("add_resp_rdy1", bus.req1_ready, 0);
    bus.req1_valid = 1'b0;   // withdrawn before any grant
    tick();
    chk("add_idle_valid", bus.rsp_valid, 0);
    chk("cancel_busy", busy, 0);
    #1;
    chk("cancel_rdy1", bus.req1_ready, 0);

    // subtract with borrow: 3-5 -> 0E borrow 1
    bus.req1_valid = 1'b1;
    bus.req1_a = 4'h3; bus.req1_b = 4'h5; bus.req1_sel = 2'b01;
    #1;
    chk("sub1_rdy1", bus.req1_ready, 1);
    tick();
    bus.req1_valid = 1'b0;
    tick();
    chk("sub1_id", bus.rsp_id, 1);
    chk("sub1_result", bus.rsp_result, 8'h0E);
    chk("sub1_cout", bus.rsp_cout, 1);
    tick();

    // subtract without borrow: 5-3 -> 02 borrow 0
    bus.req1_valid = 1'b1;
    bus.req1_a = 4'h5; bus.req1_b = 4'h3; bus.req1_sel = 2'b11;
    tick();
    bus.req1_valid = 1'b0;
    tick();
    chk("sub2_id", bus.rsp_id, 1);
    chk("sub2_result", bus.rsp_result, 8'h02);
    chk("sub2_cout", bus.rsp_cout, 0);
    tick();

    // back-pressure plus operand change after grant: 7+6 -> 0D
    bus.rsp_ready = 1'b0;
    bus.req0_valid = 1'b1;
    bus.req0_a = 4'h7; bus.req0_b = 4'h6; bus.req0_sel = 2'b00;
    #1;
    chk("bp_rdy0", bus.req0_ready, 1);
    tick();
    bus.req0_a = 4'h1; bus.req0_b = 4'h1; bus.req0_sel = 2'b01;
    bus.req1_valid = 1'b1;
    bus.req1_a = 4'h2; bus.req1_b = 4'h3; bus.req1_sel = 2'b10;
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", bus.rsp_valid, 1);
      chk("bp_result", bus.rsp_result, 8'h0D);
      chk("bp_cout", bus.rsp_cout, 0);
      chk("bp_id", bus.rsp_id, 0);
      chk("bp_rdy0", bus.req0_ready, 0);
      chk("bp_rdy1", bus.req1_ready, 0);
      chk("bp_busy", busy, 1);
      tick();
    end
    bus.rsp_ready = 1'b1;
    #1;
    chk("bp_release_rdy0", bus.req0_ready, 0);
    chk("bp_release_rdy1", bus.req1_ready, 0);
    chk("bp_release_valid", bus.rsp_valid, 1);
    tick();
    chk("bp_idle_valid", bus.rsp_valid, 0);
    chk("bp_idle_busy", busy, 0);
    chk("rr_rdy1", bus.req1_ready, 1);
    chk("rr_rdy0", bus.req0_ready, 0);

    // reset during EXEC of the req1 operation
    tick();
    chk("mid_exec_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", bus.rsp_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_result", bus.rsp_result, 0);
    chk("mid_rst_cout", bus.rsp_cout, 0);
    chk("mid_rst_id", bus.rsp_id, 0);
    chk("mid_rst_rdy0", bus.req0_ready, 0);
    chk("mid_rst_rdy1", bus.req1_ready, 0);
    tick();
    chk("mid_rst_valid2", bus.rsp_valid, 0);
    tick();

    // contention from reset: grants 0,1,0,1 every 3 cycles
    bus.req0_a = 4'h2; bus.req0_b = 4'h3; bus.req0_sel = 2'b00;
    bus.req1_a = 4'h2; bus.req1_b = 4'h3; bus.req1_sel = 2'b10;
    rst_n = 1'b1;
    #1;
    for (int g = 0; g < 4; g++) begin
      chk("cont_rdy0", bus.req0_ready, (g % 2 == 0) ? 1 : 0);
      chk("cont_rdy1", bus.req1_ready, (g % 2 == 1) ? 1 : 0);
      chk("cont_idle_valid", bus.rsp_valid, 0);
      tick();
      chk("cont_exec_valid", bus.rsp_valid, 0);
      chk("cont_exec_busy", busy, 1);
      tick();
      chk("cont_resp_valid", bus.rsp_valid, 1);
      chk("cont_resp_id", bus.rsp_id, g % 2);
      chk("cont_resp_result", bus.rsp_result, (g % 2 == 0) ? 8'h05 : 8'h0F);
      chk("cont_resp_cout", bus.rsp_cout, (g % 2 == 0) ? 0 : 1);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
